// File: rtl/axis_reg_slice_pipe.sv
// rtl/axis_reg_slice_pipe.sv - cascaded AXI-Stream register slices with flush and occupancy

module axis_reg_slice_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int MODE       = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  up_valid,
  output logic                  up_ready,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [1:0]            held_nxt
);

  generate
    if (MODE == 1) begin : g_fwd
      logic                  vld_q, vld_d;
      logic [DATA_WIDTH-1:0] dat_q, dat_d;

      assign up_ready = ~vld_q | dn_ready;
      assign dn_valid = vld_q;
      assign dn_data  = dat_q;
      assign held_nxt = {1'b0, vld_d};

      // load on accept; drop the flag once the held beat leaves with nothing behind it
      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (up_valid && up_ready) begin
          vld_d = 1'b1;
          dat_d = up_data;
        end else if (dn_ready) begin
          vld_d = 1'b0;
        end
        if (flush) vld_d = 1'b0;
      end

      // state registers
      always_ff @(posedge clk) begin
        if (!resetn) begin
          vld_q <= 1'b0;
          dat_q <= '0;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end
    end else if (MODE == 2) begin : g_skid
      logic                  skid_vld_q, skid_vld_d;
      logic [DATA_WIDTH-1:0] skid_q, skid_d;

      assign up_ready = ~skid_vld_q;
      assign dn_valid = up_valid | skid_vld_q;
      assign dn_data  = skid_vld_q ? skid_q : up_data;
      assign held_nxt = {1'b0, skid_vld_d};

      // park an accepted beat when downstream stalls; release it when downstream takes it
      always_comb begin
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (up_valid && up_ready && !dn_ready) begin
          skid_vld_d = 1'b1;
          skid_d     = up_data;
        end else if (skid_vld_q && dn_ready) begin
          skid_vld_d = 1'b0;
        end
        if (flush) skid_vld_d = 1'b0;
      end

      // state registers
      always_ff @(posedge clk) begin
        if (!resetn) begin
          skid_vld_q <= 1'b0;
          skid_q     <= '0;
        end else begin
          skid_vld_q <= skid_vld_d;
          skid_q     <= skid_d;
        end
      end
    end else begin : g_full
      logic [1:0]            cnt_q, cnt_d;
      logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
      logic                  push, pop;

      assign up_ready = (cnt_q != 2'd2);
      assign dn_valid = (cnt_q != 2'd0);
      assign dn_data  = head_q;
      assign push     = up_valid && up_ready;
      assign pop      = dn_valid && dn_ready;
      assign held_nxt = cnt_d;

      // two-entry buffer: head is always the oldest beat
      always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
          2'b10: begin
            if (cnt_q == 2'd0) head_d = up_data;
            else               tail_d = up_data;
            cnt_d = cnt_q + 2'd1;
          end
          2'b01: begin
            if (cnt_q == 2'd2) head_d = tail_q;
            cnt_d = cnt_q - 2'd1;
          end
          2'b11: head_d = up_data;
          default: ;
        endcase
        if (flush) cnt_d = 2'd0;
      end

      // state registers
      always_ff @(posedge clk) begin
        if (!resetn) begin
          cnt_q  <= 2'd0;
          head_q <= '0;
          tail_q <= '0;
        end else begin
          cnt_q  <= cnt_d;
          head_q <= head_d;
          tail_q <= tail_d;
        end
      end
    end
  endgenerate

endmodule

module axis_reg_slice_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 1,
  parameter int MODE       = 3
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             flush,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(2*STAGES+1);

  generate
    if (MODE == 0) begin : g_bypass
      assign out_data  = resetn ? in_data : '0;
      assign out_valid = in_valid & resetn;
      assign in_ready  = out_ready & resetn;
      assign occupancy = '0;
    end else begin : g_chain
      // both external handshakes are blocked while in reset or flushing
      logic             pass_ok;
      logic [OCC_W-1:0] occ_q;

      assign pass_ok = resetn & ~flush;

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [DATA_WIDTH-1:0] s_up_data, s_dn_data;
        logic                  s_up_valid, s_up_ready;
        logic                  s_dn_valid, s_dn_ready;
        logic [1:0]            s_held;
        logic [OCC_W-1:0]      s_occ;

        if (k == 0) begin : g_head
          assign s_up_data  = in_data;
          assign s_up_valid = in_valid & pass_ok;
          assign s_occ      = OCC_W'(s_held);
        end else begin : g_link
          assign s_up_data  = g_stage[k-1].s_dn_data;
          assign s_up_valid = g_stage[k-1].s_dn_valid;
          assign s_occ      = g_stage[k-1].s_occ + OCC_W'(s_held);
        end

        if (k == STAGES - 1) begin : g_tail
          assign s_dn_ready = out_ready & pass_ok;
        end else begin : g_next
          assign s_dn_ready = g_stage[k+1].s_up_ready;
        end

        axis_reg_slice_stage #(
          .DATA_WIDTH (DATA_WIDTH),
          .MODE       (MODE)
        ) u_stage (
          .clk      (clk),
          .resetn   (resetn),
          .flush    (flush),
          .up_data  (s_up_data),
          .up_valid (s_up_valid),
          .up_ready (s_up_ready),
          .dn_data  (s_dn_data),
          .dn_valid (s_dn_valid),
          .dn_ready (s_dn_ready),
          .held_nxt (s_held)
        );
      end

      assign in_ready  = g_stage[0].s_up_ready & pass_ok;
      assign out_valid = g_stage[STAGES-1].s_dn_valid & pass_ok;

      // skid mode forwards input data combinationally, so mask it during reset
      if (MODE == 2) begin : g_data_mask
        assign out_data = resetn ? g_stage[STAGES-1].s_dn_data : '0;
      end else begin : g_data_reg
        assign out_data = g_stage[STAGES-1].s_dn_data;
      end

      // occupancy register tracks the sum of per-stage next-state fill levels
      always_ff @(posedge clk) begin
        if (!resetn) occ_q <= '0;
        else         occ_q <= g_stage[STAGES-1].s_occ;
      end

      assign occupancy = occ_q;
    end
  endgenerate

endmodule

// File: doc/axis_reg_slice_pipe.md
# axis_reg_slice_pipe

Parametrised AXI-Stream register pipeline: a chain of `STAGES` identical register slices, each built in one of four modes (bypass, forward, reverse, full). It also provides a synchronous flush and an occupancy count. It sits between any two streaming blocks where timing closure needs paths broken over long routes or across SLR boundaries. It is the general-purpose successor to the single-stage full register slice.

## Interface
- `DATA_WIDTH`, 64: payload width in bits (≥1).
- `STAGES`, 1: number of cascaded slices (1..8). Ignored when `MODE`=0.
- `MODE`, 3: 0 = bypass, 1 = forward-registered, 2 = reverse-registered (skid), 3 = fully registered.
- `clk`  in  1  clock; all ports synchronous to it.
- `resetn`  in  1  reset, synchronous, active-low.
- `flush`  in  1  synchronous clear; all held beats are discarded.
- `in_data`  in  `DATA_WIDTH`  upstream payload.
- `in_valid`  in  1  upstream valid.
- `in_ready`  out  1  backpressure to upstream.
- `out_data`  out  `DATA_WIDTH`  downstream payload.
- `out_valid`  out  1  downstream valid.
- `out_ready`  in  1  downstream backpressure.
- `occupancy`  out  `$clog2(2*STAGES+1)`  total beats held across all stages.

## Operation
- A beat transfers on a side when its valid and ready are both 1 on a rising edge.
- Beats leave in exactly the order they arrived. No beat is dropped or duplicated, except by `flush` or reset.
- Stage k's output feeds stage k+1's input. Stage `STAGES`-1 drives the output port.
- MODE 0: `out_data`=`in_data`, `out_valid`=`in_valid`, `in_ready`=`out_ready`, all combinational. `occupancy`=0. `flush` has no effect.
- MODE 1, per stage: one data register plus a valid flag.
  - Stage ready = ~valid | downstream ready.
  - When the stage accepts a beat, the register loads it and valid is set.
  - When the stage's output transfers and no new beat arrives, valid is cleared.
- MODE 2, per stage: one skid register plus a skid-valid flag.
  - Stage ready = ~skid_valid.
  - out_valid = in_valid | skid_valid.
  - out_data = skid_valid ? skid : in.
  - The skid register loads when a beat is accepted while downstream ready=0 and skid is empty.
  - Skid-valid clears when downstream transfers.
- MODE 3, per stage: two-entry buffer with head/tail entries and a count in 0..2.
  - ready = (count<2); out_valid = (count>0); out_data = head entry.
  - Push with count 0: the beat becomes head.
  - Push with count 1 and no pop: the beat becomes tail; head is unchanged.
  - Push and pop together with count 1: the beat becomes head; count stays 1.
  - Pop with count 2: tail moves to head.
  - Push with count 2 is impossible, since ready=0.
- `occupancy` = sum of per-stage held beats (valid flags, skid flags, or counts). It is registered and reflects state after the previous edge.
- `flush`=1 in a cycle:
  - `in_ready`=0 and `out_valid`=0 in that cycle, so no transfer occurs on either side.
  - At that edge all valid flags and counts clear.
- `flush` and reset override any handshake in the same cycle.

## Timing
- Reset values:
  - `out_valid`=0 and `occupancy`=0.
  - `out_data`=0, because all data registers reset to 0.
  - `in_ready`=0 while `resetn`=0. After reset it is 1 in MODE 1/2/3 from the first cycle following release.
- Latency from input transfer to earliest `out_valid`:
  - MODE 0: 0 cycles (same cycle).
  - MODE 2: 0 cycles (same cycle).
  - MODE 1: `STAGES` cycles.
  - MODE 3: `STAGES` cycles.
- Throughput is 1 beat/cycle in every mode under continuous valid/ready.
- Registered outputs, with no combinational input→output path:
  - MODE 1: `out_valid` and `out_data`.
  - MODE 2: `in_ready`.
  - MODE 3: `out_valid`, `out_data` and `in_ready`.
- Full condition, with `out_ready` held 0:
  - MODE 1: `in_ready` drops once `STAGES` beats are held.
  - MODE 2: `in_ready` drops once `STAGES` beats are held.
  - MODE 3: `in_ready` drops once 2×`STAGES` beats are held.
- After `out_ready` rises from full, MODE 3 accepts a new input in the cycle after the first pop.

## Test plan
- **Reset:** assert `resetn`=0 for 3 cycles with `in_valid`=1.
  - During reset: `in_ready`=0, `out_valid`=0, `occupancy`=0, `out_data`=0.
  - After release: `in_ready`=1 next cycle (MODE 1/2/3).
- **Streaming:** MODE 3, `STAGES`=3, send 0x00..0x3F back-to-back with `out_ready`=1.
  - First `out_valid` 3 cycles after the first accept.
  - 64 beats out in order, one per cycle.
  - `occupancy` steady at 3.
- **Fill and drain:** MODE 3, `STAGES`=2, `out_ready`=0, push continuously.
  - Exactly 4 beats accepted, `in_ready`=0, `occupancy`=4.
  - Raise `out_ready`: beats 0,1,2,3 emerge in order, then the stream resumes.
- **Random backpressure:** each of MODE 1/2/3 with `STAGES` 1 and 4, random `in_valid`/`out_ready` at 50%, 10 000 beats.
  - Scoreboard shows no loss, duplication or reorder.
  - MODE 1 `out_*` and MODE 2 `in_ready` never change combinationally with inputs.
- **Flush:** MODE 3, `STAGES`=2 holding 0xA1, 0xA2, 0xA3; assert `flush` for 1 cycle with `in_valid`=1 and `out_ready`=1.
  - No transfer in the flush cycle.
  - Next cycle `occupancy`=0 and `out_valid`=0.
  - Next accepted beat 0xB0 is the first output.
- **Bypass:** MODE 0, toggle `out_ready` each cycle.
  - `in_ready` equals `out_ready` in the same cycle.
  - `out_data` equals `in_data` in the same cycle.
  - `occupancy`=0 throughout.
